// File: rtl/hsi_rx_arbiter.sv
// Round-robin arbiter sharing one serial frame decoder between N_CH rx lines.
// Locks onto a start bit, then holds the grant until the message ends, errors or times out.
module hsi_rx_arbiter #(
  parameter int N_CH    = 4,
  parameter int CH_W    = 2,
  parameter int TIMEOUT = 200
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic [N_CH-1:0] line,
  output logic            dc_d,
  output logic            dc_n_rst,
  input  logic            dc_q_rdy,
  input  logic            dc_err,
  input  logic            dc_msg_end,
  output logic [N_CH-1:0] grant,
  output logic            busy,
  output logic            msg_done,
  output logic            msg_abort,
  output logic [1:0]      abort_cause,
  output logic [CH_W-1:0] rx_ch,
  output logic [7:0]      rx_len
);

  localparam int SW = CH_W + 1;
  localparam logic [SW-1:0] NCH = SW'(N_CH);
  localparam logic [7:0] WD_MAX = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RX,
    FLUSH
  } state_e;

  state_e          state_q;
  logic [N_CH-1:0] grant_q;
  logic            busy_q;
  logic            dc_d_q;
  logic            dc_n_rst_q;
  logic            done_q;
  logic            abort_q;
  logic [1:0]      cause_q;
  logic [CH_W-1:0] rx_ch_q;
  logic [7:0]      rx_len_q;
  logic [CH_W-1:0] ptr_q;
  logic [CH_W-1:0] ch_q;
  logic [7:0]      cnt_q;
  logic [7:0]      wd_q;
  logic            rdy_q;

  logic            win_found;
  logic [CH_W-1:0] win_idx;
  logic [CH_W-1:0] cand;
  logic [CH_W-1:0] ptr_d;
  logic [7:0]      cnt_d;
  logic            rise;
  logic            timeout;

  function automatic logic [CH_W-1:0] wrap(input logic [SW-1:0] s);
    return CH_W'((s >= NCH) ? s - NCH : s);
  endfunction

  // Scan from the farthest offset down so the nearest requester to ptr wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      cand = wrap({1'b0, ptr_q} + SW'(k));
      if (!line[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign ptr_d   = wrap({1'b0, win_idx} + SW'(1));
  assign rise    = dc_q_rdy & ~rdy_q;
  assign cnt_d   = (rise && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
  assign timeout = (wd_q == WD_MAX) && !rise;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      dc_d_q     <= 1'b1;
      dc_n_rst_q <= 1'b0;
      done_q     <= 1'b0;
      abort_q    <= 1'b0;
      cause_q    <= 2'd0;
      rx_ch_q    <= '0;
      rx_len_q   <= 8'd0;
      ptr_q      <= '0;
      ch_q       <= '0;
      cnt_q      <= 8'd0;
      wd_q       <= 8'd0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q   <= dc_q_rdy;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          dc_n_rst_q <= 1'b1;
          if (win_found) begin
            grant_q <= N_CH'(1) << win_idx;
            busy_q  <= 1'b1;
            ch_q    <= win_idx;
            cnt_q   <= 8'd0;
            wd_q    <= 8'd0;
            dc_d_q  <= 1'b0;
            ptr_q   <= ptr_d;
            state_q <= RX;
          end else begin
            dc_d_q <= 1'b1;
          end
        end
        RX: begin
          dc_d_q <= line[ch_q];
          cnt_q  <= cnt_d;
          wd_q   <= rise ? 8'd0 : wd_q + 8'd1;
          if (dc_err || dc_msg_end || timeout) begin
            rx_ch_q    <= ch_q;
            rx_len_q   <= cnt_d;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            dc_d_q     <= 1'b1;
            dc_n_rst_q <= 1'b0;
            state_q    <= FLUSH;
            if (dc_err) begin
              abort_q <= 1'b1;
              cause_q <= 2'd1;
            end else if (dc_msg_end) begin
              done_q  <= 1'b1;
              cause_q <= 2'd0;
            end else begin
              abort_q <= 1'b1;
              cause_q <= 2'd2;
            end
          end
        end
        FLUSH: begin
          dc_n_rst_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant       = grant_q;
  assign busy        = busy_q;
  assign dc_d        = dc_d_q;
  assign dc_n_rst    = dc_n_rst_q;
  assign msg_done    = done_q;
  assign msg_abort   = abort_q;
  assign abort_cause = cause_q;
  assign rx_ch       = rx_ch_q;
  assign rx_len      = rx_len_q;

endmodule

// File: doc/hsi_rx_arbiter.md
# hsi_rx_arbiter

Round-robin arbiter that shares one serial frame decoder between `N_CH` idle-high serial receive lines. It scans the lines for a start bit and locks the decoder onto the winning line. It holds that grant until the decoder reports message end, a parity error, or a watchdog timeout. It then pulse-resets the decoder and reports the channel and byte count of the finished or aborted message.

## Interface

Parameters:
- `N_CH`, 4: number of serial lines (2..8).
- `CH_W`, 2: channel index width, equal to ceil(log2(`N_CH`)).
- `TIMEOUT`, 200: clock cycles allowed since grant or since the last byte before the message is aborted (1..255).

Ports:
- `clk`  in  1  system clock, 8x the serial bit rate.
- `n_rst`  in  1  reset: synchronous, active-low.
- `line`  in  N_CH  serial inputs, idle high, start bit = 0.
- `dc_d`  out  1  serial data to the decoder.
- `dc_n_rst`  out  1  decoder reset, active-low.
- `dc_q_rdy`  in  1  decoder byte-ready.
- `dc_err`  in  1  decoder parity error.
- `dc_msg_end`  in  1  decoder end-of-message.
- `grant`  out  N_CH  one-hot; the line currently owning the decoder.
- `busy`  out  1  a message is in progress.
- `msg_done`  out  1  one-cycle pulse: message completed.
- `msg_abort`  out  1  one-cycle pulse: message aborted.
- `abort_cause`  out  2  0 none, 1 parity error, 2 timeout.
- `rx_ch`  out  CH_W  channel of the last completed or aborted message.
- `rx_len`  out  8  bytes received in that message.

## Operation

- **State machine:** IDLE, RX, FLUSH. All outputs are registered.
- **IDLE**
  - Each cycle, a line is requesting when `line[i]==0`.
  - Search order is `ptr`, `ptr+1`, and so on, wrapping modulo `N_CH`. The first requester wins.
  - On a win:
    - `grant <= onehot(i)`, `busy<=1`, `ch<=i`.
    - `cnt<=0` (byte counter); `wd<=0` (watchdog counter).
    - `dc_d <= line[i]` (i.e. 0).
    - `ptr <= (i+1) mod N_CH`, then go to RX.
  - With no requester, `dc_d<=1`.
- **RX**
  - `dc_d <= line[ch]` every cycle, so the decoder sees a uniform 1-cycle delayed copy of the granted line and bit alignment is kept.
  - Byte counting: on a rising edge of `dc_q_rdy` (high now, low the previous cycle), `cnt<=cnt+1` (saturates at 255) and `wd<=0`. Otherwise `wd<=wd+1`.
  - Exit conditions, in priority order:
    1. `dc_err` → abort, cause 1.
    2. `dc_msg_end` → done.
    3. `wd==TIMEOUT-1` → abort, cause 2.
  - On exit:
    - Latch `rx_ch<=ch`.
    - Latch `rx_len` as `cnt`, including any byte counted in the same cycle.
    - Pulse `msg_done` or `msg_abort` and set `abort_cause`: 0 on done, 1 or 2 on abort.
    - Set `grant<=0`, `busy<=0`, `dc_d<=1`, `dc_n_rst<=0`, then go to FLUSH.
- **FLUSH:** one cycle; `dc_n_rst<=1`, then go to IDLE.
  - A line still low during FLUSH is arbitrated in the following IDLE cycle.
- **Non-granted lines:** activity on them is ignored while busy. Those frames are lost; this is by design.
- **Counter widths:** `cnt` and `wd` are 8 bits unsigned. `ptr` is `CH_W` bits.
- **Reset** (`n_rst==0` at a clock edge, at any time including mid-message):
  - `grant=0`, `busy=0`, `dc_d=1`, `dc_n_rst=0`.
  - `msg_done=0`, `msg_abort=0`, `abort_cause=0`, `rx_ch=0`, `rx_len=0`.
  - `ptr=0`, `cnt=0`, `wd=0`, state IDLE.
  - `dc_n_rst` rises to 1 on the first clock with `n_rst==1`.

## Timing

- Start-bit latency: `line[i]` falls and is sampled at edge t. At t, `grant` is set and `dc_d` goes to 0. The decoder detects start at t+1.
- In RX, `dc_d` at edge t+1 equals `line[ch]` at edge t.
- Completion latency: `dc_msg_end`, `dc_err` or the timeout condition is sampled at edge t. The pulse, `rx_*`, `grant=0` and `dc_n_rst=0` are visible after t. `dc_n_rst` returns to 1 after t+1. The earliest new grant is at t+2.
- `msg_done` and `msg_abort` are mutually exclusive and exactly one cycle wide. `abort_cause` and `rx_*` hold until the next completion.
- Boundary cases:
  - `dc_q_rdy` rising edge together with `dc_msg_end`: the byte is counted, then done.
  - `dc_err` together with `dc_msg_end`: abort, cause 1.
  - Timeout together with `dc_msg_end`: done.
  - Timeout together with a `dc_q_rdy` edge: no timeout, because `wd` is cleared.
  - `dc_msg_end` with `cnt==0`: done with `rx_len=0`.
  - A `dc_q_rdy` level held high for several cycles counts as one byte.

## Test plan

- Line 1 sends a 3-byte message with correct parity, then idles high → grant=0010 one cycle after the start bit; `msg_done` pulse with `rx_ch=1`, `rx_len=3`, `abort_cause=0`; one-cycle `dc_n_rst` low pulse.
- Lines 0 and 2 drop low in the same cycle with `ptr=0` → line 0 granted; line 2 traffic ignored. The next simultaneous request from lines 0 and 2 grants line 2 (`ptr=1`).
- Second byte on line 3 has bad parity, so the decoder pulses `dc_err` → `msg_abort`, `abort_cause=1`, `rx_ch=3`, `rx_len=1`.
- Line 2 sends a start bit, then holds low forever → `msg_abort`, `abort_cause=2`, exactly `TIMEOUT` cycles after the grant cycle; `rx_len=0`.
- `n_rst` asserted for one cycle mid-message on line 1 → next cycle `grant=0`, `busy=0`, `dc_d=1`, `dc_n_rst=0`, `rx_len=0`; `dc_n_rst=1` one cycle after release; no `msg_done` or `msg_abort` pulse.
- `dc_q_rdy` and `dc_msg_end` asserted in the same cycle as the second byte → `msg_done` with `rx_len=2`.
